// File: rtl/ohsm_monitor_if.sv
`default_nettype none
// ============================================================================
// Module      : ohsm_monitor_if
// Description : Phase-bus and status bundle between sequencer side and the
//               one-hot phase monitor.
// Revision    : 1.0 - initial release
// ============================================================================
interface ohsm_monitor_if #(
    parameter int CNT_W = 8
);
    logic [3:0]       SGlobal_in;
    logic             clr_err;
    logic [1:0]       phase_idx;
    logic             phase_valid;
    logic             cycle_done;
    logic [CNT_W-1:0] cycle_count;
    logic             err_onehot;
    logic             err_seq;
    logic             synced;

    // Producer / observer side: drives the phase bus, reads monitor status.
    modport master (
        output SGlobal_in,
        output clr_err,
        input  phase_idx,
        input  phase_valid,
        input  cycle_done,
        input  cycle_count,
        input  err_onehot,
        input  err_seq,
        input  synced
    );

    modport slave (
        input  SGlobal_in,
        input  clr_err,
        output phase_idx,
        output phase_valid,
        output cycle_done,
        output cycle_count,
        output err_onehot,
        output err_seq,
        output synced
    );
endinterface
`default_nettype wire

// File: rtl/ohsm_monitor.sv
`default_nettype none
// ============================================================================
// Module      : ohsm_monitor
// Description : Receive-side checker for the 4-bit one-hot phase bus; decodes
//               the phase, checks encoding and S1->S2->S3->S4 order, counts
//               completed cycles and keeps sticky error flags.
// Revision    : 1.0 - initial release
// ============================================================================
module ohsm_monitor #(
    parameter int CNT_W = 8
) (
    input  wire logic      clk,
    input  wire logic      reset,
    ohsm_monitor_if.slave  bus
);

    localparam logic [3:0] c_S1 = 4'b1000;
    localparam logic [3:0] c_S2 = 4'b0100;
    localparam logic [3:0] c_S3 = 4'b0010;
    localparam logic [3:0] c_S4 = 4'b0001;
    localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic [0:0] {
        WAIT_S1 = 1'b0,
        TRACK   = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [3:0]       r_prev_phase;
    logic [3:0]       w_prev_nxt;
    logic [1:0]       r_phase_idx;
    logic [1:0]       w_idx_nxt;
    logic             r_phase_valid;
    logic             w_valid_nxt;
    logic             r_cycle_done;
    logic             w_done_nxt;
    logic [CNT_W-1:0] r_cycle_count;
    logic [CNT_W-1:0] w_count_nxt;
    logic             r_err_onehot;
    logic             r_err_seq;
    logic             w_onehot_set;
    logic             w_seq_set;
    logic             r_synced;

    logic [3:0]       w_code;
    logic             w_legal;
    logic [1:0]       w_dec;
    logic             w_succ_ok;

    assign w_code  = bus.SGlobal_in;
    assign w_legal = $onehot(w_code);

    always_comb begin
        w_dec = 2'd0;
        case (w_code)
            c_S1:    w_dec = 2'd0;
            c_S2:    w_dec = 2'd1;
            c_S3:    w_dec = 2'd2;
            c_S4:    w_dec = 2'd3;
            default: w_dec = 2'd0;
        endcase
    end

    // S1 is the only phase allowed to dwell.
    always_comb begin
        w_succ_ok = 1'b0;
        case (r_prev_phase)
            c_S1:    w_succ_ok = (w_code == c_S1) || (w_code == c_S2);
            c_S2:    w_succ_ok = (w_code == c_S3);
            c_S3:    w_succ_ok = (w_code == c_S4);
            c_S4:    w_succ_ok = (w_code == c_S1);
            default: w_succ_ok = 1'b0;
        endcase
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_prev_nxt   = r_prev_phase;
        w_idx_nxt    = r_phase_idx;
        w_valid_nxt  = w_legal;
        w_done_nxt   = 1'b0;
        w_count_nxt  = r_cycle_count;
        w_onehot_set = 1'b0;
        w_seq_set    = 1'b0;

        if (!w_legal) begin
            w_onehot_set = 1'b1;
            w_state_nxt  = WAIT_S1;
        end else begin
            w_idx_nxt = w_dec;
            case (r_state)
                WAIT_S1: begin
                    if (w_code == c_S1) begin
                        w_state_nxt = TRACK;
                        w_prev_nxt  = c_S1;
                    end
                end
                TRACK: begin
                    if (w_succ_ok) begin
                        w_prev_nxt = w_code;
                        if (r_prev_phase == c_S4) begin
                            w_done_nxt = 1'b1;
                            if (r_cycle_count != c_CNT_MAX)
                                w_count_nxt = r_cycle_count + 1'b1;
                        end
                    end else begin
                        // A misplaced S1 does not re-lock here; the next sample will.
                        w_seq_set   = 1'b1;
                        w_state_nxt = WAIT_S1;
                    end
                end
                default: w_state_nxt = WAIT_S1;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= WAIT_S1;
            r_prev_phase  <= 4'd0;
            r_phase_idx   <= 2'd0;
            r_phase_valid <= 1'b0;
            r_cycle_done  <= 1'b0;
            r_cycle_count <= '0;
            r_err_onehot  <= 1'b0;
            r_err_seq     <= 1'b0;
            r_synced      <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_prev_phase  <= w_prev_nxt;
            r_phase_idx   <= w_idx_nxt;
            r_phase_valid <= w_valid_nxt;
            r_cycle_done  <= w_done_nxt;
            r_cycle_count <= w_count_nxt;
            // A fresh error on the clearing edge takes priority.
            r_err_onehot  <= w_onehot_set | (r_err_onehot & ~bus.clr_err);
            r_err_seq     <= w_seq_set    | (r_err_seq    & ~bus.clr_err);
            r_synced      <= (w_state_nxt == TRACK);
        end
    end

    assign bus.phase_idx   = r_phase_idx;
    assign bus.phase_valid = r_phase_valid;
    assign bus.cycle_done  = r_cycle_done;
    assign bus.cycle_count = r_cycle_count;
    assign bus.err_onehot  = r_err_onehot;
    assign bus.err_seq     = r_err_seq;
    assign bus.synced      = r_synced;

endmodule
`default_nettype wire

// File: tb/tb_ohsm_monitor.sv
`default_nettype none
// ============================================================================
// Module      : tb_ohsm_monitor
// Description : Directed self-checking bench for ohsm_monitor (CNT_W=8 and 2).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ohsm_monitor;

    logic clk;
    logic reset;
    int   n_pass;
    int   n_total;

    ohsm_monitor_if #(.CNT_W(8)) if0 ();
    ohsm_monitor_if #(.CNT_W(2)) if1 ();

    ohsm_monitor #(.CNT_W(8)) u_dut0 (.clk(clk), .reset(reset), .bus(if0.slave));
    ohsm_monitor #(.CNT_W(2)) u_dut1 (.clk(clk), .reset(reset), .bus(if1.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {synced, phase_idx, phase_valid, err_onehot, err_seq, cycle_done}
    logic [6:0] st0;
    logic [6:0] st1;
    assign st0 = {if0.synced, if0.phase_idx, if0.phase_valid, if0.err_onehot, if0.err_seq, if0.cycle_done};
    assign st1 = {if1.synced, if1.phase_idx, if1.phase_valid, if1.err_onehot, if1.err_seq, if1.cycle_done};

    // Apply inputs, take one rising edge, sample 1 time unit later.
    task automatic cyc(input logic [3:0] code, input logic clr, input logic rst_v);
        if0.SGlobal_in = code;  if1.SGlobal_in = code;
        if0.clr_err    = clr;   if1.clr_err    = clr;
        reset          = rst_v;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        cyc(4'b1000, 1'b0, 1'b1);
        cyc(4'b1000, 1'b0, 1'b1);
        n_total++;
        if (st0 !== 7'b0 || if0.cycle_count !== 8'd0) $display("FAIL reset_state: got st=%b cnt=%0d want st=0000000 cnt=0", st0, if0.cycle_count);
        else n_pass++;
        cyc(4'b1000, 1'b0, 1'b0);
        n_total++;
        if (st0 !== 7'b1_00_1_0_0_0 || if0.cycle_count !== 8'd0) $display("FAIL reset_release: got st=%b cnt=%0d want st=1001000 cnt=0", st0, if0.cycle_count);
        else n_pass++;
    endtask

    task automatic test_full_cycles();
        logic [3:0] seq [4];
        int pulses;
        seq[0] = 4'b0100; seq[1] = 4'b0010; seq[2] = 4'b0001; seq[3] = 4'b1000;
        pulses = 0;
        for (int c = 0; c < 3; c++) begin
            for (int p = 0; p < 4; p++) begin
                logic [1:0] ei;
                logic       ed;
                cyc(seq[p], 1'b0, 1'b0);
                ei = (p == 3) ? 2'd0 : 2'(p + 1);
                ed = (p == 3);
                if (if0.cycle_done) pulses++;
                n_total++;
                if (st0 !== {1'b1, ei, 1'b1, 1'b0, 1'b0, ed})
                    $display("FAIL full_cycle c%0d p%0d: got st=%b want st=%b", c, p, st0, {1'b1, ei, 1'b1, 1'b0, 1'b0, ed});
                else n_pass++;
            end
            n_total++;
            if (if0.cycle_count !== 8'(c + 1)) $display("FAIL cycle_count c%0d: got %0d want %0d", c, if0.cycle_count, c + 1);
            else n_pass++;
        end
        n_total++;
        if (pulses !== 3) $display("FAIL done_pulses: got %0d want 3", pulses);
        else n_pass++;
        // S1 dwell: no further pulse
        cyc(4'b1000, 1'b0, 1'b0);
        n_total++;
        if (st0 !== 7'b1_00_1_0_0_0 || if0.cycle_count !== 8'd3) $display("FAIL s1_dwell: got st=%b cnt=%0d want st=1001000 cnt=3", st0, if0.cycle_count);
        else n_pass++;
    endtask

    task automatic test_bad_encoding();
        cyc(4'b0100, 1'b0, 1'b0);
        cyc(4'b0110, 1'b0, 1'b0);
        n_total++;
        if (st0 !== 7'b0_01_0_1_0_0) $display("FAIL bad_code: got st=%b want st=0010100", st0);
        else n_pass++;
        cyc(4'b0100, 1'b0, 1'b0);
        n_total++;
        if (st0 !== 7'b0_01_1_1_0_0) $display("FAIL wait_ignore_s2: got st=%b want st=0011100", st0);
        else n_pass++;
        cyc(4'b1000, 1'b0, 1'b0);
        n_total++;
        if (st0 !== 7'b1_00_1_1_0_0) $display("FAIL relock: got st=%b want st=1001100", st0);
        else n_pass++;
        cyc(4'b1000, 1'b1, 1'b0);
        n_total++;
        if (st0 !== 7'b1_00_1_0_0_0) $display("FAIL clear_onehot: got st=%b want st=1001000", st0);
        else n_pass++;
    endtask

    task automatic test_illegal_seq();
        cyc(4'b1000, 1'b0, 1'b0);
        cyc(4'b0100, 1'b0, 1'b0);
        cyc(4'b0001, 1'b0, 1'b0);
        n_total++;
        if (st0 !== 7'b0_11_1_0_1_0 || if0.cycle_count !== 8'd3) $display("FAIL s2_to_s4: got st=%b cnt=%0d want st=0111010 cnt=3", st0, if0.cycle_count);
        else n_pass++;
        cyc(4'b1000, 1'b0, 1'b0);
        cyc(4'b0100, 1'b0, 1'b0);
        // Misplaced S1 errors without locking; the following S1 locks.
        cyc(4'b1000, 1'b0, 1'b0);
        n_total++;
        if (st0 !== 7'b0_00_1_0_1_0) $display("FAIL s2_to_s1: got st=%b want st=0001010", st0);
        else n_pass++;
        cyc(4'b1000, 1'b0, 1'b0);
        n_total++;
        if (st0 !== 7'b1_00_1_0_1_0 || if0.cycle_count !== 8'd3) $display("FAIL seq_sticky: got st=%b cnt=%0d want st=1001010 cnt=3", st0, if0.cycle_count);
        else n_pass++;
    endtask

    task automatic test_clear_vs_error();
        cyc(4'b0000, 1'b0, 1'b0);
        n_total++;
        if (st0 !== 7'b0_00_0_1_1_0) $display("FAIL zero_code: got st=%b want st=0000110", st0);
        else n_pass++;
        cyc(4'b0000, 1'b1, 1'b0);
        n_total++;
        if (st0 !== 7'b0_00_0_1_0_0) $display("FAIL error_beats_clear: got st=%b want st=0000100", st0);
        else n_pass++;
        cyc(4'b1000, 1'b1, 1'b0);
        n_total++;
        if (st0 !== 7'b1_00_1_0_0_0 || if0.cycle_count !== 8'd3) $display("FAIL clean_clear: got st=%b cnt=%0d want st=1001000 cnt=3", st0, if0.cycle_count);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        cyc(4'b0100, 1'b0, 1'b0);
        cyc(4'b0010, 1'b0, 1'b0);
        cyc(4'b0001, 1'b0, 1'b1);
        n_total++;
        if (st0 !== 7'b0 || if0.cycle_count !== 8'd0) $display("FAIL reset_mid: got st=%b cnt=%0d want st=0000000 cnt=0", st0, if0.cycle_count);
        else n_pass++;
        cyc(4'b0001, 1'b0, 1'b0);
        n_total++;
        if (st0 !== 7'b0_11_1_0_0_0) $display("FAIL post_reset_s4: got st=%b want st=0111000", st0);
        else n_pass++;
        cyc(4'b1000, 1'b0, 1'b0);
        n_total++;
        if (st0 !== 7'b1_00_1_0_0_0 || if0.cycle_count !== 8'd0) $display("FAIL post_reset_lock: got st=%b cnt=%0d want st=1001000 cnt=0", st0, if0.cycle_count);
        else n_pass++;
    endtask

    task automatic test_saturation();
        logic [1:0] exp_cnt [5];
        int pulses;
        exp_cnt[0] = 2'd1; exp_cnt[1] = 2'd2; exp_cnt[2] = 2'd3; exp_cnt[3] = 2'd3; exp_cnt[4] = 2'd3;
        pulses = 0;
        cyc(4'b1000, 1'b0, 1'b1);
        cyc(4'b1000, 1'b0, 1'b0);
        for (int c = 0; c < 5; c++) begin
            cyc(4'b0100, 1'b0, 1'b0);
            cyc(4'b0010, 1'b0, 1'b0);
            cyc(4'b0001, 1'b0, 1'b0);
            cyc(4'b1000, 1'b0, 1'b0);
            if (if1.cycle_done) pulses++;
            n_total++;
            if (if1.cycle_count !== exp_cnt[c] || st1 !== 7'b1_00_1_0_0_1)
                $display("FAIL sat_count c%0d: got cnt=%0d st=%b want cnt=%0d st=1001001", c, if1.cycle_count, st1, exp_cnt[c]);
            else n_pass++;
        end
        n_total++;
        if (pulses !== 5) $display("FAIL sat_pulses: got %0d want 5", pulses);
        else n_pass++;
        n_total++;
        if (if0.cycle_count !== 8'd5) $display("FAIL wide_count: got %0d want 5", if0.cycle_count);
        else n_pass++;
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        reset   = 1'b1;
        if0.SGlobal_in = 4'b0000; if1.SGlobal_in = 4'b0000;
        if0.clr_err    = 1'b0;    if1.clr_err    = 1'b0;
        test_reset();
        test_full_cycles();
        test_bad_encoding();
        test_illegal_seq();
        test_clear_vs_error();
        test_reset_mid();
        test_saturation();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ohsm_monitor.md
Name: ohsm_monitor

Overview:
- Receive-side checker for the 4-bit one-hot phase bus `SGlobal` produced by the phase sequencer.
- Decodes the one-hot phase to a binary index and checks the one-hot encoding and the legal sequence S1->S2->S3->S4->S1 (S1 may dwell).
- Counts completed phase cycles and raises sticky error flags.
- Sits on the consumer side of the sequencer, in the same clock domain.

Parameters:
- CNT_W, 8, width of the completed-cycle counter (saturating).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- SGlobal_in  input  4  one-hot phase from the sequencer: S1=4'b1000, S2=4'b0100, S3=4'b0010, S4=4'b0001.
- clr_err  input  1  clears err_onehot and err_seq.
- phase_idx  output  2  decoded phase: S1=0, S2=1, S3=2, S4=3.
- phase_valid  output  1  last sample was a legal one-hot code.
- cycle_done  output  1  one-cycle pulse on each observed S4->S1.
- cycle_count  output  CNT_W  completed cycles, saturating.
- err_onehot  output  1  sticky; a non-one-hot code was seen.
- err_seq  output  1  sticky; an illegal phase transition was seen.
- synced  output  1  monitor is locked to the sequence (state TRACK).

Behaviour:
- Timing:
  - SGlobal_in is sampled every rising edge. All outputs are registered.
  - An effect from sample N is visible after edge N, i.e. 1-cycle latency.
- Reset (synchronous, active-high):
  - Dominates every other input.
  - All outputs go to 0; state goes to WAIT_S1; the internal prev_phase register goes to 0.
- One-hot check:
  - Legal codes are exactly one bit set.
  - A legal code sets phase_valid=1 and updates phase_idx.
  - 4'b0000 or more than one bit set: phase_valid=0, phase_idx holds its previous value, err_onehot<=1, state->WAIT_S1.
  - The one-hot check applies in every state.
- State machine (2 states):
  - WAIT_S1:
    - Entered on reset or after any error.
    - Legal non-S1 codes are ignored; no err_seq, no counting.
    - A legal S1 -> TRACK; prev_phase<=S1.
    - synced=0.
  - TRACK:
    - synced=1.
    - Legal successors: S1->{S1,S2}, S2->S3, S3->S4, S4->S1.
    - A legal successor sets prev_phase<=current.
    - An illegal legal-coded successor (e.g. S2->S2, S1->S3, S4->S2) sets err_seq<=1 and state->WAIT_S1. cycle_done stays 0.
    - If the offending code is S1, the monitor re-locks at the next sample, not on the erroring sample.
- Cycle completion:
  - In TRACK, prev_phase=S4 with current=S1 pulses cycle_done=1 for exactly one cycle.
  - On the same edge cycle_count increments, unless it equals 2^CNT_W-1, where it holds.
- Error clearing:
  - clr_err=1 clears err_onehot and err_seq on that edge.
  - If a new error is detected on the same edge, that flag is set; the error wins over the clear.
  - clr_err does not affect cycle_count, state or synced.
- Reset mid-cycle (e.g. during S3): everything returns to reset values on that edge. The next S1 after reset re-locks.

Test Plan:
- Reset then idle: reset=1 for 2 cycles with SGlobal_in=4'b1000, then release -> after the first edge synced=1, phase_idx=0, phase_valid=1, cycle_count=0, no errors.
- Full cycles: drive 1000,0100,0010,0001 repeated 3 times, then 1000 -> cycle_done pulses 3 times, each for 1 cycle one edge after each 0001->1000 transition; cycle_count=3; phase_idx follows 0,1,2,3 with 1-cycle lag.
- Bad encoding: while in TRACK drive 4'b0110 -> phase_valid=0, phase_idx unchanged, err_onehot=1, synced=0; then 0100 -> still synced=0; then 1000 -> synced=1.
- Illegal sequence: 1000,0100,0001 -> err_seq=1 and synced=0 after the 0001 edge; cycle_count unchanged; err_seq stays set until clr_err.
- Clear vs new error: clr_err=1 on the same edge as 4'b0000 with err_onehot already 1 -> err_onehot stays 1; clr_err=1 on a clean edge -> both flags 0.
- Saturation (CNT_W=2): run 5 full cycles -> cycle_count reads 1,2,3,3,3, and cycle_done still pulses 5 times.
